spi_master_engine: RTL
======================

Name: spi_master_engine

Overview:
- Single-lane SPI master engine, mode 0 (CPOL=0, CPHA=0): the initiator side of the SPI link whose slave-side bus model drives spi_sdo0 back.
- Accepts one transfer command of 1..32 bits on a valid/ready interface and selects one of four chip selects.
- Shifts the command data out MSB-first on spi_sdo0 and captures spi_sdi0 in parallel.
- Returns the captured word as a one-cycle response pulse; sits between the register/bus front end and the pads.

Parameters:
- CLK_DIV, 4: SCLK half-period in HCLK cycles; legal >=1.
- CS_SETUP, 2: HCLK cycles from CSn falling to the first SCLK rising edge's low phase start; legal >=1.
- CS_HOLD, 2: HCLK cycles from the last SCLK falling edge to CSn rising; legal >=1.

Ports:
- HCLK in 1: clock; all logic on the rising edge.
- HRESET in 1: asynchronous, active-high reset.
- cmd_valid in 1: transfer request.
- cmd_ready out 1: engine idle and able to accept.
- cmd_data in 32: transmit word; bits [len:0] are used.
- cmd_len in 5: bit count minus 1 (0 = 1 bit, 31 = 32 bits).
- cmd_cs in 2: chip select index 0..3.
- rsp_valid out 1: one-cycle pulse at transfer end.
- rsp_data out 32: received bits right-aligned, upper bits zero.
- busy out 1: high from accept to the rsp_valid cycle inclusive.
- spi_clk out 1: SCLK, idles low.
- spi_csn0..spi_csn3 out 1 each: active-low chip selects.
- spi_sdo0 out 1: MOSI.
- spi_sdi0 in 1: MISO.

Behaviour:
- Reset values (asynchronous on HRESET): state=IDLE; cmd_ready=1; busy=0; rsp_valid=0; rsp_data=0; spi_clk=0; all spi_csn*=1; spi_sdo0=0; counters and shift registers 0.
- Reset mid-transfer: all outputs return to reset values immediately. No rsp_valid is generated for the aborted transfer.
- States: IDLE, SETUP, SCK_LO, SCK_HI, HOLD, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready (edge T): latch data, len and cs; go to SETUP.
  - From T+1: spi_csn[cmd_cs]=0, spi_sdo0=cmd_data[cmd_len], busy=1.
- SETUP: lasts CS_SETUP cycles, then SCK_LO.
- SCK_LO: spi_clk=0 for CLK_DIV cycles, then SCK_HI.
- SCK_HI:
  - spi_clk=1 for CLK_DIV cycles.
  - On the edge entering SCK_HI: rx <= {rx[30:0], spi_sdi0}.
  - On leaving SCK_HI, if bits remain: spi_sdo0 takes the next lower bit and the state returns to SCK_LO. Otherwise go to HOLD.
- HOLD: spi_clk=0, CSn still low, for CS_HOLD cycles, then DONE.
- DONE (1 cycle):
  - All CSn=1, rsp_valid=1, rsp_data=rx masked to len+1 bits, spi_sdo0=0.
  - busy=1 this cycle; cmd_ready=0.
  - Next cycle: IDLE.
- CSn low duration: exactly CS_SETUP + (len+1)*2*CLK_DIV + CS_HOLD cycles.
- CSn high gap between back-to-back transfers: at least 2 cycles (DONE + IDLE accept cycle).
- cmd_valid held high continuously: the next command is accepted on the first IDLE cycle after DONE.
- Inputs during a transfer: cmd_* changes are ignored; latched values are used throughout.
- rsp_data holds its value until the next DONE.
- Only the selected CSn ever goes low; no two CSn are ever low together.

Optional Feature:
- Macro: SPI_MASTER_LSBF_EN.
- Defined:
  - Adds input port cmd_lsb_first (1 bit), latched at accept.
  - When it is 1: transmit order is cmd_data[0] up to cmd_data[len]. Received bits are placed so that the first received bit lands in rsp_data[0] and the last in rsp_data[len].
  - When it is 0: MSB-first behaviour as above.
- Not defined: the port is absent and the engine is MSB-first only.

Test Plan:
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=1; cmd_len=7, cmd_data=0xA5, cs=0; slave returns bits 0,0,1,1,1,1,0,0 -> spi_sdo0 sequence 1,0,1,0,0,1,0,1; spi_csn0 low 34 cycles; rsp_data=0x0000003C; one rsp_valid pulse.
- cmd_len=31, cmd_data=0xDEADBEEF, loopback spi_sdi0=spi_sdo0 -> rsp_data=0xDEADBEEF; 32 SCLK rising edges.
- cmd_len=0, cmd_data=0x1, cs=3, sdi=1 -> one SCLK pulse; only spi_csn3 low; rsp_data=0x00000001.
- cmd_valid held high with two queued commands -> second accepted exactly 2 cycles after first CSn rises; busy low for exactly 1 cycle between them.
- HRESET asserted during 4th bit -> same cycle: all CSn=1, spi_clk=0, cmd_ready=1; no rsp_valid; next command completes normally.
- CLK_DIV=1 -> SCLK toggles every HCLK cycle; results identical to the first scenario.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: one 1..32-bit transfer per command, four chip selects, full duplex.
// Optional LSB-first ordering (cmd_lsb_first port) when SPI_MASTER_LSBF_EN is defined.
module spi_master_engine #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [4:0]  cmd_len,
  input  logic [1:0]  cmd_cs,
`ifdef SPI_MASTER_LSBF_EN
  input  logic        cmd_lsb_first,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_csn0,
  output logic        spi_csn1,
  output logic        spi_csn2,
  output logic        spi_csn3,
  output logic        spi_sdo0,
  input  logic        spi_sdi0
);
  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_M1 = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     bits_q, bits_d;
  logic [4:0]     len_q, len_d;
  logic [1:0]     cs_q, cs_d;
  logic           lsb_q, lsb_d;
  logic [31:0]    tx_q, tx_d;
  logic [31:0]    rx_q, rx_d;
  logic [31:0]    rsp_q, rsp_d;
  logic           lsb_in;
  logic [31:0]    len_mask;
  logic           active;

`ifdef SPI_MASTER_LSBF_EN
  assign lsb_in = cmd_lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign len_mask = 32'hFFFF_FFFF >> (5'd31 - len_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    len_d   = len_q;
    cs_d    = cs_q;
    lsb_d   = lsb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        cnt_d   = SETUP_M1;
        bits_d  = cmd_len;
        len_d   = cmd_len;
        cs_d    = cmd_cs;
        lsb_d   = lsb_in;
        // MSB-first parks the first bit at tx[31]; LSB-first shifts out of tx[0]
        tx_d    = lsb_in ? cmd_data : (cmd_data << (5'd31 - cmd_len));
        rx_d    = '0;
      end
      SETUP: if (cnt_q == '0) begin
        state_d = SCK_LO;
        cnt_d   = DIV_M1;
      end else cnt_d = cnt_q - 1'b1;
      SCK_LO: if (cnt_q == '0) begin
        state_d = SCK_HI;
        cnt_d   = DIV_M1;
        if (lsb_q) begin
          rx_d         = rx_q >> 1;
          rx_d[len_q]  = spi_sdi0;
        end else begin
          rx_d = {rx_q[30:0], spi_sdi0};
        end
      end else cnt_d = cnt_q - 1'b1;
      SCK_HI: if (cnt_q == '0) begin
        if (bits_q != '0) begin
          state_d = SCK_LO;
          cnt_d   = DIV_M1;
          bits_d  = bits_q - 1'b1;
          tx_d    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_M1;
        end
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) begin
        state_d = DONE;
        rsp_d   = rx_q & len_mask;
      end else cnt_d = cnt_q - 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      cs_q    <= '0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      cs_q    <= cs_d;
      lsb_q   <= lsb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rsp_q   <= rsp_d;
    end
  end

  // Outputs decode straight from state so an async reset clears the pads at once
  assign active    = (state_q == SETUP) || (state_q == SCK_LO) ||
                     (state_q == SCK_HI) || (state_q == HOLD);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_q;
  assign spi_clk   = (state_q == SCK_HI);
  assign spi_sdo0  = active & (lsb_q ? tx_q[0] : tx_q[31]);
  assign spi_csn0  = !(active && cs_q == 2'd0);
  assign spi_csn1  = !(active && cs_q == 2'd1);
  assign spi_csn2  = !(active && cs_q == 2'd2);
  assign spi_csn3  = !(active && cs_q == 2'd3);
endmodule
